// File: rtl/sys_led_scanner_pkg.sv
// Shared definitions for the SYS LED/debug scanner: scan states, select width
// and the manual-select range test.
package sys_led_scanner_pkg;

  localparam int SYS_SEL_W = 8;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_FROZEN = 2'd2
  } scan_state_e;

  // True when a manual select addresses an existing channel (no modulo folding).
  function automatic logic sel_in_range(input logic [SYS_SEL_W-1:0] sel,
                                        input int unsigned ch_count);
    return ({24'd0, sel} < ch_count);
  endfunction

endpackage

// File: rtl/sys_dwell_counter.sv
// Dwell counter for auto-scan: counts 0..DWELL-1 while enabled, tick marks the last
// cycle of a dwell. clr makes the current cycle count as zero.
module sys_dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_eff_s;

  // Effective count this cycle and the end-of-dwell pulse.
  always_comb begin
    count_eff_s = count_r;
    tick        = 1'b0;
    if (clr) begin
      count_eff_s = {CNT_W{1'b0}};
    end else begin
      count_eff_s = count_r;
    end
    if (en && (count_eff_s == LAST_CNT)) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

  // Count register: advances when enabled, clears on request, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= tick ? {CNT_W{1'b0}} : (count_eff_s + CNT_W'(1));
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end
  end

endmodule

// File: rtl/sys_led_scanner.sv
// LED/debug output selector: captures CH_COUNT debug channels and shows one on the
// board LEDs, either manually selected or auto-scanned, with a freeze hold.
module sys_led_scanner
  import sys_led_scanner_pkg::*;
#(
  parameter int CH_COUNT = 8,
  parameter int DATA_W   = 27,
  parameter int DWELL    = 4
) (
  input  logic                       SYS_clk,
  input  logic                       SYS_reset,
  input  logic                       SYS_mode,
  input  logic                       SYS_freeze,
  input  logic [SYS_SEL_W-1:0]       SYS_output_sel,
  input  logic [CH_COUNT*DATA_W-1:0] SYS_ch_data,
  input  logic [CH_COUNT-1:0]        SYS_ch_valid,
  output logic [DATA_W-1:0]          SYS_leds,
  output logic                       SYS_leds_valid,
  output logic [SYS_SEL_W-1:0]       SYS_cur_ch
);

  localparam int SEL_W = $clog2(CH_COUNT);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH_COUNT - 1);

  scan_state_e          state_r;
  scan_state_e          state_next_s;
  logic [DATA_W-1:0]    cap_r [CH_COUNT];
  logic [SEL_W-1:0]     pos_r;
  logic [SEL_W-1:0]     pos_next_s;
  logic [SEL_W-1:0]     start_ch_s;
  logic [SEL_W-1:0]     sel_idx_s;
  logic                 sel_ok_s;
  logic                 scan_en_s;
  logic                 scan_clr_s;
  logic                 dwell_tick_s;
  logic [DATA_W-1:0]    leds_next_s;
  logic                 leds_valid_next_s;
  logic [SYS_SEL_W-1:0] cur_ch_next_s;

  assign sel_ok_s  = sel_in_range(SYS_output_sel, CH_COUNT);
  assign sel_idx_s = SYS_output_sel[SEL_W-1:0];

  sys_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (SYS_clk),
    .reset (SYS_reset),
    .en    (scan_en_s),
    .clr   (scan_clr_s),
    .tick  (dwell_tick_s)
  );

  // Next state, dwell control and the channel the scan shows this cycle.
  always_comb begin
    state_next_s = state_r;
    scan_en_s    = 1'b0;
    scan_clr_s   = 1'b0;
    start_ch_s   = pos_r;
    if (SYS_freeze) begin
      state_next_s = ST_FROZEN;
    end else if (!SYS_mode) begin
      state_next_s = ST_MANUAL;
      scan_clr_s   = 1'b1;
    end else begin
      state_next_s = ST_AUTO;
      scan_en_s    = 1'b1;
      case (state_r)
        ST_MANUAL: start_ch_s = sel_ok_s ? sel_idx_s : {SEL_W{1'b0}};
        ST_FROZEN: begin
          start_ch_s = pos_r;
          scan_clr_s = 1'b1;
        end
        ST_AUTO:   start_ch_s = pos_r;
        default:   start_ch_s = {SEL_W{1'b0}};
      endcase
    end
  end

  // Display values and scan position for the coming edge.
  always_comb begin
    leds_next_s       = SYS_leds;
    leds_valid_next_s = SYS_leds_valid;
    cur_ch_next_s     = SYS_cur_ch;
    pos_next_s        = pos_r;
    if (SYS_freeze) begin
      leds_next_s       = SYS_leds;
      leds_valid_next_s = SYS_leds_valid;
      cur_ch_next_s     = SYS_cur_ch;
      pos_next_s        = pos_r;
    end else if (!SYS_mode) begin
      leds_next_s       = sel_ok_s ? cap_r[sel_idx_s] : {DATA_W{1'b0}};
      leds_valid_next_s = sel_ok_s;
      cur_ch_next_s     = SYS_output_sel;
      // Track the manual channel so a later auto entry via freeze starts there.
      pos_next_s        = sel_ok_s ? sel_idx_s : {SEL_W{1'b0}};
    end else begin
      leds_next_s       = cap_r[start_ch_s];
      leds_valid_next_s = 1'b1;
      cur_ch_next_s     = SYS_SEL_W'(start_ch_s);
      if (dwell_tick_s) begin
        pos_next_s = (start_ch_s == LAST_CH) ? {SEL_W{1'b0}} : (start_ch_s + SEL_W'(1));
      end else begin
        pos_next_s = start_ch_s;
      end
    end
  end

  // State register.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_r <= ST_MANUAL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture registers, scan position and registered LED outputs.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      pos_r          <= {SEL_W{1'b0}};
      SYS_leds       <= {DATA_W{1'b0}};
      SYS_leds_valid <= 1'b0;
      SYS_cur_ch     <= {SYS_SEL_W{1'b0}};
    end else begin
      pos_r          <= pos_next_s;
      SYS_leds       <= leds_next_s;
      SYS_leds_valid <= leds_valid_next_s;
      SYS_cur_ch     <= cur_ch_next_s;
    end
    for (int k = 0; k < CH_COUNT; k++) begin
      if (SYS_reset) begin
        cap_r[k] <= {DATA_W{1'b0}};
      end else if (!SYS_freeze && SYS_ch_valid[k]) begin
        cap_r[k] <= SYS_ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_sys_led_scanner.sv
// Self-checking bench for sys_led_scanner: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_sys_led_scanner;
  localparam int CH = 8;
  localparam int DW = 27;
  localparam int DWELL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          freeze = 1'b0;
  logic [7:0]    sel = 8'd0;
  logic [CH*DW-1:0] ch_data = '0;
  logic [CH-1:0] ch_valid = '0;
  logic [DW-1:0] leds;
  logic          leds_valid;
  logic [7:0]    cur_ch;

  int pass_cnt = 0;
  int check_cnt = 0;

  // Behavioural model: mode 0 manual, 1 auto, 2 frozen; dwell counted as cycles spent.
  logic [DW-1:0] m_cap [CH];
  int            m_state = 0;
  int            m_pos = 0;
  int            m_spent = 0;
  logic [DW-1:0] m_leds = '0;
  logic          m_valid = 1'b0;
  int            m_cur = 0;

  sys_led_scanner #(.CH_COUNT(CH), .DATA_W(DW), .DWELL(DWELL)) dut (
    .SYS_clk(clk), .SYS_reset(rst), .SYS_mode(mode), .SYS_freeze(freeze),
    .SYS_output_sel(sel), .SYS_ch_data(ch_data), .SYS_ch_valid(ch_valid),
    .SYS_leds(leds), .SYS_leds_valid(leds_valid), .SYS_cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic step();
    int start;
    if (rst) begin
      m_state = 0; m_pos = 0; m_spent = 0;
      m_leds = '0; m_valid = 1'b0; m_cur = 0;
      for (int k = 0; k < CH; k++) m_cap[k] = '0;
    end else begin
      if (freeze) begin
        m_state = 2;
      end else if (!mode) begin
        m_state = 0; m_spent = 0; m_cur = int'(sel);
        if (int'(sel) < CH) begin
          m_leds = m_cap[sel]; m_valid = 1'b1; m_pos = int'(sel);
        end else begin
          m_leds = '0; m_valid = 1'b0; m_pos = 0;
        end
      end else begin
        if (m_state == 0) start = (int'(sel) < CH) ? int'(sel) : 0;
        else start = m_pos;
        if (m_state != 1) m_spent = 0;
        m_leds = m_cap[start]; m_valid = 1'b1; m_cur = start;
        m_spent = m_spent + 1;
        if (m_spent == DWELL) begin
          m_spent = 0; m_pos = (start + 1) % CH;
        end else begin
          m_pos = start;
        end
        m_state = 1;
      end
      if (!freeze)
        for (int k = 0; k < CH; k++)
          if (ch_valid[k]) m_cap[k] = ch_data[k*DW +: DW];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    logic [DW-1:0] d;
    for (int k = 0; k < CH; k++) begin
      d = DW'($urandom());
      ch_data[k*DW +: DW] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    randomize_data();
    ch_valid = 8'hFF; mode = 1'b1; sel = 8'd5;
    step(); step();
    rst = 1'b0; ch_valid = 8'h00; freeze = 1'b1;
    check_cnt++; if (leds !== 27'd0) $display("FAIL reset_leds got %h want 0", leds); else pass_cnt++;
    check_cnt++; if (leds_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", leds_valid); else pass_cnt++;
    check_cnt++; if (cur_ch !== 8'd0) $display("FAIL reset_cur got %0d want 0", cur_ch); else pass_cnt++;
    freeze = 1'b0; mode = 1'b0;
  endtask

  task automatic test_manual();
    ch_data[3*DW +: DW] = 27'h5A5A5A; ch_valid = 8'h08; sel = 8'd3; mode = 1'b0;
    step();
    ch_valid = 8'h00;
    check_cnt++; if (leds !== 27'd0) $display("FAIL manual_latency got %h want 0", leds); else pass_cnt++;
    step();
    check_cnt++; if (leds !== 27'h5A5A5A) $display("FAIL manual_leds got %h want 5a5a5a", leds); else pass_cnt++;
    check_cnt++; if (leds_valid !== 1'b1 || cur_ch !== 8'd3)
      $display("FAIL manual_sel got valid=%b cur=%0d want valid=1 cur=3", leds_valid, cur_ch); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      randomize_data(); ch_valid = CH'($urandom()); sel = 8'($urandom_range(0, 11));
      step();
      check_cnt++;
      if (leds !== m_leds || leds_valid !== m_valid || int'(cur_ch) != m_cur)
        $display("FAIL manual_rand got %h/%b/%0d want %h/%b/%0d", leds, leds_valid, cur_ch, m_leds, m_valid, m_cur);
      else pass_cnt++;
    end
    ch_valid = 8'h00;
  endtask

  task automatic test_out_of_range();
    sel = 8'd9; step();
    check_cnt++; if (leds !== 27'd0 || leds_valid !== 1'b0 || cur_ch !== 8'd9)
      $display("FAIL out_of_range got %h/%b/%0d want 0/0/9", leds, leds_valid, cur_ch); else pass_cnt++;
    sel = 8'd8; step();
    check_cnt++; if (leds_valid !== 1'b0 || cur_ch !== 8'd8)
      $display("FAIL sel_eq_count got %b/%0d want 0/8", leds_valid, cur_ch); else pass_cnt++;
  endtask

  task automatic test_auto();
    int exp_seq [12] = '{6, 6, 6, 6, 7, 7, 7, 7, 0, 0, 0, 0};
    randomize_data(); ch_valid = 8'hFF; sel = 8'd6; mode = 1'b0;
    step();
    ch_valid = 8'h00; mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      sel = 8'($urandom());
      check_cnt++;
      if (int'(cur_ch) != exp_seq[i] || leds !== m_leds || leds_valid !== 1'b1)
        $display("FAIL auto_seq[%0d] got cur=%0d leds=%h valid=%b want cur=%0d leds=%h valid=1",
                 i, cur_ch, leds, leds_valid, exp_seq[i], m_leds);
      else pass_cnt++;
    end
  endtask

  task automatic test_freeze();
    logic [DW-1:0] old2, old_leds;
    int exp_seq [5] = '{2, 2, 2, 2, 3};
    mode = 1'b0; sel = 8'd2; step();
    old2 = m_cap[2];
    mode = 1'b1; step();
    freeze = 1'b1; old_leds = leds;
    ch_data[2*DW +: DW] = ~old2; ch_valid = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      check_cnt++;
      if (leds !== old_leds || cur_ch !== 8'd2 || leds_valid !== 1'b1)
        $display("FAIL freeze_hold got %h/%0d want %h/2", leds, cur_ch, old_leds);
      else pass_cnt++;
    end
    ch_valid = 8'h00; freeze = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_cnt++;
      if (int'(cur_ch) != exp_seq[i]) $display("FAIL freeze_release[%0d] got %0d want %0d", i, cur_ch, exp_seq[i]);
      else pass_cnt++;
    end
    mode = 1'b0; sel = 8'd2; step();
    check_cnt++; if (leds !== old2) $display("FAIL freeze_nocap got %h want %h", leds, old2); else pass_cnt++;
  endtask

  task automatic test_reset_mid_auto();
    logic [DW-1:0] d;
    sel = 8'd5; mode = 1'b1; step(); step();
    check_cnt++; if (cur_ch !== 8'd5) $display("FAIL pre_reset_cur got %0d want 5", cur_ch); else pass_cnt++;
    rst = 1'b1; step(); rst = 1'b0;
    check_cnt++; if (leds !== 27'd0 || leds_valid !== 1'b0 || cur_ch !== 8'd0)
      $display("FAIL mid_auto_reset got %h/%b/%0d want 0/0/0", leds, leds_valid, cur_ch); else pass_cnt++;
    mode = 1'b0; sel = 8'd1; d = DW'($urandom()) | 27'd1;
    ch_data[1*DW +: DW] = d; ch_valid = 8'h02;
    step(); ch_valid = 8'h00;
    check_cnt++; if (leds !== 27'd0) $display("FAIL same_edge_old got %h want 0", leds); else pass_cnt++;
    step();
    check_cnt++; if (leds !== d) $display("FAIL same_edge_new got %h want %h", leds, d); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      randomize_data();
      ch_valid = CH'($urandom());
      rst    = ($urandom_range(0, 49) == 0);
      freeze = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 8'($urandom_range(0, 12));
      step();
      check_cnt++;
      if (leds !== m_leds || leds_valid !== m_valid || int'(cur_ch) != m_cur)
        $display("FAIL random[%0d] got %h/%b/%0d want %h/%b/%0d", i, leds, leds_valid, cur_ch, m_leds, m_valid, m_cur);
      else pass_cnt++;
    end
    rst = 1'b0; freeze = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < CH; k++) m_cap[k] = '0;
    test_reset();
    test_manual();
    test_out_of_range();
    test_auto();
    test_freeze();
    test_reset_mid_auto();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
